// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key sequencer and the downstream symbol
// decoder. Both sides import this package so that the pattern encoding (bit
// order, dot/dash polarity, field widths) can never drift apart.
//
// Contents:
//   SYM_W, LEN_W  - widths of the pattern and element-count fields
//   DOT, DASH     - element encoding inside the pattern
//   state_e       - sequencer state encoding
package morse_pkg;

    localparam int SYM_W = 5;
    localparam int LEN_W = 3;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS    = 3'd1,
        GAP      = 3'd2,
        EMIT     = 3'd3,
        WAIT_REL = 3'd4
    } state_e;

endpackage

// File: rtl/morse_key_sync.sv
// Brings the raw, asynchronous key line into the clock domain and derives
// single-cycle edge strobes from the synchronised level.
//
// Ports:
//   clk_i   - system clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   key_i   - raw key level, 1 = pressed
//   k_o     - synchronised key level (two flops behind key_i)
//   rise_o  - one-cycle strobe when k_o goes 0 -> 1
//   fall_o  - one-cycle strobe when k_o goes 1 -> 0
module morse_key_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic k_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic k_q;
    logic k_prev_q;

    // Two-flop synchroniser followed by a history flop for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q   <= 1'b0;
            k_q      <= 1'b0;
            k_prev_q <= 1'b0;
        end else begin
            meta_q   <= key_i;
            k_q      <= meta_q;
            k_prev_q <= k_q;
        end
    end

    assign k_o    = k_q;
    assign rise_o = k_q & ~k_prev_q;
    assign fall_o = ~k_q & k_prev_q;

endmodule

// File: rtl/morse_key_ctrl.sv
// Morse key sequencer. Times each press and release of the synchronised key,
// classifies presses as dot or dash, collects up to five elements into a
// left-aligned pattern and hands the finished character downstream over a
// valid/ready handshake.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   key        - raw key level, asynchronous to clk, 1 = pressed
//   sym_bits   - character pattern, first element in bit 4, dot=0 dash=1
//   sym_len    - number of elements in the character, 1..5
//   sym_valid  - sym_bits/sym_len hold a finished character
//   sym_ready  - downstream accepts the character
//   busy       - sequencer is anywhere other than IDLE
module morse_key_ctrl
    import morse_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MIN_PRESS = 2,
    parameter int DOT_MAX   = 4,
    parameter int GAP_CHAR  = 8,
    parameter int MAX_SYM   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key,
    output logic [SYM_W-1:0] sym_bits,
    output logic [LEN_W-1:0] sym_len,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_LEN   = CNT_W'(MIN_PRESS);
    localparam logic [CNT_W-1:0] DOT_LEN   = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CHAR - 1);
    localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(MAX_SYM);
    localparam logic [SYM_W-1:0] FIRST_BIT = {1'b1, {(SYM_W-1){1'b0}}};

    logic k;
    logic key_rise;
    logic key_fall;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0] buf_q, buf_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [LEN_W-1:0] len_inc;
    logic [SYM_W-1:0] elem_mask;
    logic             elem_val;

    morse_key_sync u_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .key_i  (key),
        .k_o    (k),
        .rise_o (key_rise),
        .fall_o (key_fall)
    );

    // Saturating so that an arbitrarily long press still reads as a dash.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign len_inc   = len_q + LEN_W'(1);
    // Next free slot in the left-aligned pattern.
    assign elem_mask = FIRST_BIT >> len_q;
    assign elem_val  = (cnt_q > DOT_LEN) ? DASH : DOT;

    // State, duration counter, pattern buffer and element count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic. The counter is reloaded on every state entry:
    // 1 when entering PRESS (the rise cycle is the first pressed cycle),
    // 0 everywhere else.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        len_d   = len_q;

        unique case (state_q)
            IDLE: begin
                if (key_rise) begin
                    state_d = PRESS;
                    cnt_d   = CNT_ONE;
                end
            end

            PRESS: begin
                if (key_fall) begin
                    cnt_d = '0;
                    if (cnt_q < MIN_LEN) begin
                        // Glitch: nothing recorded, and a gap in progress
                        // starts over from this release.
                        if (len_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        buf_d = elem_val ? (buf_q | elem_mask) : (buf_q & ~elem_mask);
                        len_d = len_inc;
                        if (len_inc == LEN_FULL) begin
                            state_d = EMIT;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            GAP: begin
                // A new press takes priority over the gap terminal count.
                if (key_rise) begin
                    state_d = PRESS;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            EMIT: begin
                // Key activity here is deliberately ignored; a key still
                // held at hand-off is parked in WAIT_REL until released.
                if (sym_ready) begin
                    buf_d = '0;
                    len_d = '0;
                    if (k) begin
                        state_d = WAIT_REL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            WAIT_REL: begin
                if (key_fall) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign sym_bits  = buf_q;
    assign sym_len   = len_q;
    assign sym_valid = (state_q == EMIT);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_morse_key_ctrl.sv
// Bench for morse_key_ctrl. Each character is described as a list of press
// lengths and the key-low gaps between them; the expected pattern, length and
// hand-off latency are worked out from those run lengths alone.
module tb_morse_key_ctrl;

    localparam int GAP_CHAR  = 8;
    localparam int DOT_MAX   = 4;
    localparam int MIN_PRESS = 2;
    localparam int MAX_SYM   = 5;

    logic       clk      = 1'b0;
    logic       resetN   = 1'b0;
    logic       key      = 1'b0;
    logic       symReady = 1'b0;
    logic [4:0] symBits;
    logic [2:0] symLen;
    logic       symValid;
    logic       busy;

    int cyc        = 0;
    int checkCount = 0;
    int passCount  = 0;
    int pressQ[$];
    int gapQ[$];

    morse_key_ctrl #(
        .CNT_W     (16),
        .MIN_PRESS (MIN_PRESS),
        .DOT_MAX   (DOT_MAX),
        .GAP_CHAR  (GAP_CHAR),
        .MAX_SYM   (MAX_SYM)
    ) dut (
        .clk       (clk),
        .reset     (resetN),
        .key       (key),
        .sym_bits  (symBits),
        .sym_len   (symLen),
        .sym_valid (symValid),
        .sym_ready (symReady),
        .busy      (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Rising-edge counter; an input driven at a negedge is sampled at edge cyc+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Waits for the next falling edge (outputs may be sampled by the caller
    // right after return) and then drives the inputs for the next rising edge.
    task automatic applyStimulus(input logic kv, input logic rv);
        @(negedge clk);
        key      = kv;
        symReady = rv;
    endtask

    // Character expected from the press lengths alone.
    function automatic void modelChar(output logic [4:0] bits, output int len);
        bits = '0;
        len  = 0;
        foreach (pressQ[i]) begin
            if (pressQ[i] >= MIN_PRESS && len < MAX_SYM) begin
                if (pressQ[i] > DOT_MAX) bits[4-len] = 1'b1;
                len++;
            end
        end
    endfunction

    // Drives one character from pressQ/gapQ, waits for the hand-off, applies
    // holdCycles of backpressure (optionally pressing the key meanwhile) and
    // checks pattern, latency, stability and the return to IDLE.
    task automatic runChar(input string name, input int holdCycles, input bit emitPress, input bit stopAtValid);
        logic [4:0] expBits;
        int expLen, expLat, relCyc, relW, validCyc, busyFrom;
        bit earlyValid, busyDrop, unstable, extra, relBusy;
        modelChar(expBits, expLen);
        expLat     = (expLen == MAX_SYM) ? 2 : GAP_CHAR + 2;
        validCyc   = -1;
        busyFrom   = -1;
        earlyValid = 0;
        busyDrop   = 0;
        unstable   = 0;
        extra      = 0;
        relBusy    = 0;
        checkOutput({name, "/startBusy"}, 32'(busy), 0);
        checkOutput({name, "/startValid"}, 32'(symValid), 0);

        for (int i = 0; i < pressQ.size(); i++) begin
            for (int c = 0; c < pressQ[i]; c++) begin
                applyStimulus(1'b1, 1'b0);
                if (symValid) earlyValid = 1;
                if (busyFrom >= 0 && cyc >= busyFrom && !busy) busyDrop = 1;
                if (busyFrom < 0 && c == 0 && pressQ[i] >= MIN_PRESS) busyFrom = cyc + 3;
            end
            if (i < pressQ.size() - 1) begin
                for (int c = 0; c < gapQ[i]; c++) begin
                    applyStimulus(1'b0, 1'b0);
                    if (symValid) earlyValid = 1;
                    if (busyFrom >= 0 && cyc >= busyFrom && !busy) busyDrop = 1;
                end
            end
        end

        applyStimulus(1'b0, 1'b0);
        if (symValid) earlyValid = 1;
        relCyc = cyc + 1;
        for (int w = 0; w < GAP_CHAR + 20; w++) begin
            applyStimulus(1'b0, 1'b0);
            if (symValid) begin
                validCyc = cyc;
                break;
            end
            if (busyFrom >= 0 && cyc >= busyFrom && !busy) busyDrop = 1;
        end

        if (expLen == 0) begin
            checkOutput({name, "/noChar"}, 32'(validCyc < 0), 1);
            checkOutput({name, "/idleAfter"}, 32'(busy), 0);
            return;
        end
        if (validCyc < 0) begin
            checkOutput({name, "/validTimeout"}, 0, 1);
            return;
        end
        checkOutput({name, "/earlyValid"}, 32'(earlyValid), 0);
        checkOutput({name, "/busyHeld"}, 32'(busyDrop), 0);
        checkOutput({name, "/latency"}, 32'(validCyc - relCyc), 32'(expLat));
        checkOutput({name, "/bits"}, 32'(symBits), 32'(expBits));
        checkOutput({name, "/len"}, 32'(symLen), 32'(expLen));
        if (stopAtValid) return;

        for (int j = 0; j < holdCycles; j++) begin
            applyStimulus(emitPress, 1'b0);
            if (!symValid || symBits !== expBits || symLen != 3'(expLen) || !busy) unstable = 1;
        end
        applyStimulus(emitPress, 1'b1);
        if (!symValid || symBits !== expBits || symLen != 3'(expLen)) unstable = 1;
        applyStimulus(emitPress, 1'b0);
        checkOutput({name, "/stableUnderBp"}, 32'(unstable), 0);
        checkOutput({name, "/validDrop"}, 32'(symValid), 0);
        checkOutput({name, "/bitsCleared"}, 32'({symBits, symLen}), 0);
        checkOutput({name, "/busyAfterXfer"}, 32'(busy), 32'(emitPress));

        if (emitPress) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                applyStimulus(1'b1, 1'b0);
                if (!busy || symValid) relBusy = 1;
            end
            applyStimulus(1'b0, 1'b0);
            relW = cyc + 1;
            applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0);
            checkOutput({name, "/waitRelHeld"}, 32'({relBusy, busy}), 32'b01);
            applyStimulus(1'b0, 1'b0);
            checkOutput({name, "/waitRelExit"}, 32'({busy, 32'(cyc - relW)}), 32'(2));
        end

        for (int q = 0; q < GAP_CHAR + 6; q++) begin
            applyStimulus(1'b0, 1'b0);
            if (symValid) extra = 1;
        end
        checkOutput({name, "/noExtraChar"}, 32'(extra), 0);
        checkOutput({name, "/idleAfter"}, 32'(busy), 0);
    endtask

    // Asserts reset between clock edges and checks the outputs clear at once.
    task automatic resetMid(input string name);
        checkOutput({name, "/busyBefore"}, 32'(busy), 1);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput({name, "/rstValid"}, 32'(symValid), 0);
        checkOutput({name, "/rstBits"}, 32'(symBits), 0);
        checkOutput({name, "/rstLen"}, 32'(symLen), 0);
        checkOutput({name, "/rstBusy"}, 32'(busy), 0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        resetN = 1'b1;
        applyStimulus(1'b0, 1'b0);
    endtask

    // Directed scenarios first, then randomised characters.
    initial begin
        int hold, target;
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset/valid", 32'(symValid), 0);
        checkOutput("reset/bits", 32'(symBits), 0);
        checkOutput("reset/len", 32'(symLen), 0);
        checkOutput("reset/busy", 32'(busy), 0);
        resetN = 1'b1;
        applyStimulus(1'b0, 1'b0);

        pressQ = '{3, 7};          gapQ = '{4};
        runChar("dotDash", 0, 1'b0, 1'b0);
        pressQ = '{3, 3, 3, 3, 7}; gapQ = '{3, 3, 3, 3};
        runChar("fiveElem", 1, 1'b0, 1'b0);
        pressQ = '{1};             gapQ = '{};
        runChar("glitchIdle", 0, 1'b0, 1'b0);
        pressQ = '{6, 1};          gapQ = '{5};
        runChar("glitchGap", 0, 1'b0, 1'b0);
        pressQ = '{3, 7};          gapQ = '{4};
        runChar("backpressure", 10, 1'b1, 1'b0);
        pressQ = '{4, 5};          gapQ = '{3};
        runChar("dotMaxEdge", 2, 1'b0, 1'b0);
        pressQ = '{2};             gapQ = '{};
        runChar("minPress", 0, 1'b0, 1'b0);
        pressQ = '{3, 6};          gapQ = '{GAP_CHAR};
        runChar("gapEdge", 0, 1'b0, 1'b0);

        for (int c = 0; c < 6; c++) applyStimulus(1'b1, 1'b0);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0);
        for (int c = 0; c < 5; c++) applyStimulus(1'b1, 1'b0);
        resetMid("rstPress");
        pressQ = '{5, 2};          gapQ = '{2};
        runChar("afterRstPress", 0, 1'b0, 1'b0);

        pressQ = '{7, 3};          gapQ = '{2};
        runChar("midEmit", 0, 1'b0, 1'b1);
        resetMid("rstEmit");
        pressQ = '{3, 3, 8};       gapQ = '{1, 6};
        runChar("afterRstEmit", 0, 1'b0, 1'b0);

        for (int e = 0; e < 40; e++) begin
            pressQ.delete();
            gapQ.delete();
            target = int'($urandom_range(1, 5));
            for (int v = 0; v < target; v++) begin
                if ($urandom_range(0, 4) == 0) begin
                    pressQ.push_back(1);
                    gapQ.push_back(int'($urandom_range(1, GAP_CHAR)));
                end
                if ($urandom_range(0, 1) == 1) pressQ.push_back(int'($urandom_range(MIN_PRESS, DOT_MAX)));
                else pressQ.push_back(int'($urandom_range(DOT_MAX + 1, 12)));
                gapQ.push_back(int'($urandom_range(1, GAP_CHAR)));
            end
            if (target < MAX_SYM && $urandom_range(0, 3) == 0) pressQ.push_back(1);
            hold = int'($urandom_range(0, 10));
            runChar("rand", hold, (hold >= 3) && ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
